regpipe_elastic: RTL and testbench

//   Parametrised elastic pipeline of DEPTH register stages with a valid/ready handshake.
//   - Generalises the plain enable/clear pipeline register.
//   - Per-stage valid bits let bubbles collapse, so a downstream stall does not freeze stages that are empty.
//   - Flush provides the same squash function as the old synchronous clear.

---
 rtl/regpipe_elastic.sv | 94 +++++++++
 tb/tb_regpipe_elastic.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regpipe_elastic.sv
// Elastic register pipeline: DEPTH stages with valid/ready handshake.
// Each stage has its own valid bit, so bubbles collapse even when the output stalls.
// Flush squashes every stage synchronously. When CLEAR_DATA is set, flush also zeroes the data.
module regpipe_elastic #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 2,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]             occ_q, occ_d;
  logic [DEPTH-1:0]            adv;

  // Advance chain: a stage may load if it is empty or the stage after it moves.
  always_comb begin
    adv            = '0;
    adv[DEPTH-1]   = ~valid_q[DEPTH-1] | out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = ~valid_q[i] | adv[i+1];
    end
  end

  // Next state for the stage registers. Flush has priority over normal movement.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      if (CLEAR_DATA) begin
        data_d = '0;
      end
    end else begin
      if (adv[0]) begin
        valid_d[0] = in_valid;
        // A bubble does not overwrite data, so out_data keeps its last value when empty.
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
  end

  // Occupancy is registered, so it is computed as the popcount of the next valid vector.
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + CntW'(valid_d[i]);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      data_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      occ_q   <= occ_d;
    end
  end

  // Handshake outputs. Flush blocks transfers in both directions for that cycle.
  always_comb begin
    in_ready  = adv[0] & ~flush;
    out_valid = valid_q[DEPTH-1] & ~flush;
    out_data  = data_q[DEPTH-1];
    occupancy = occ_q;
  end

endmodule

// File: tb/tb_regpipe_elastic.sv
// Self-checking bench for regpipe_elastic (DEPTH=3, WIDTH=16, CLEAR_DATA=1).
module tb_regpipe_elastic;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] occupancy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regpipe_elastic #(
    .WIDTH     (W),
    .DEPTH     (D),
    .CLEAR_DATA(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    rst = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0 || occupancy !== '0 || out_data !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: ov=%b occ=%0d od=%h ir=%b, want 0 0 0 1",
               out_valid, occupancy, out_data, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(16'h0100 + i);
      tick();
    end
    in_valid = 1'b0;
    tests++;
    if (occupancy !== CW'(3) || out_valid !== 1'b1 || out_data !== 16'h0100) begin
      fails++;
      $display("FAIL reset_prefill: occ=%0d ov=%b od=%h, want 3 1 0100",
               occupancy, out_valid, out_data);
    end
    // Reset asserted between edges must clear state immediately.
    #2 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || occupancy !== '0 || out_data !== '0) begin
      fails++;
      $display("FAIL reset_async: ov=%b occ=%0d od=%h, want 0 0 0", out_valid, occupancy, out_data);
    end
    #1 rst = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || occupancy !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ir=%b occ=%0d ov=%b, want 1 0 0", in_ready, occupancy, out_valid);
    end
  endtask

  task automatic test_stream();
    int acc = 0;
    int taken = 0;
    logic exp_v = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      in_valid = (k <= 8);
      in_data  = W'(k);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_in_ready: k=%0d got %b want 1", k, in_ready);
      end
      if (exp_v) taken++;
      if (k <= 8) acc++;
      @(posedge clk);
      #1;
      // Payload accepted at edge j is at the output after edge j+D-1.
      exp_v = (k >= int'(D)) && (k - int'(D) + 1 <= 8);
      tests++;
      if (out_valid !== exp_v || (exp_v && out_data !== W'(k - int'(D) + 1))) begin
        fails++;
        $display("FAIL stream_out: k=%0d ov=%b od=%0d, want %b %0d",
                 k, out_valid, out_data, exp_v, k - int'(D) + 1);
      end
      tests++;
      if (occupancy !== CW'(acc - taken)) begin
        fails++;
        $display("FAIL stream_occ: k=%0d got %0d want %0d", k, occupancy, acc - taken);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 16'h000A; exp_seq[1] = 16'h000B; exp_seq[2] = 16'h000C; exp_seq[3] = 16'h000D;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = exp_seq[i];
      tick();
    end
    in_data = 16'h000D;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (in_ready !== 1'b0 || occupancy !== CW'(D) || out_data !== 16'h000A || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold: c=%0d ir=%b occ=%0d od=%h ov=%b, want 0 3 000a 1",
                 c, in_ready, occupancy, out_data, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_full_passthru: in_ready=%b want 1", in_ready);
    end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[j]) begin
        fails++;
        $display("FAIL stall_release: j=%0d ov=%b od=%h, want 1 %h", j, out_valid, out_data, exp_seq[j]);
      end
      tick();
      if (j == 0) in_valid = 1'b0;
    end
    tests++;
    if (occupancy !== '0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_drained: occ=%0d ov=%b, want 0 0", occupancy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0005; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 16'h0006; tick();
    in_valid = 1'b0; tick();
    tests++;
    if (occupancy !== CW'(2) || dut.valid_q !== 3'b110 || out_data !== 16'h0005 ||
        out_valid !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bubble_collapse: occ=%0d v=%b od=%h ov=%b ir=%b, want 2 110 0005 1 1",
               occupancy, dut.valid_q, out_data, out_valid, in_ready);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h0006 || occupancy !== CW'(1)) begin
      fails++;
      $display("FAIL bubble_drain: ov=%b od=%h occ=%0d, want 1 0006 1", out_valid, out_data, occupancy);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(16'h0A00 + i);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h0BAD; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_cycle: ir=%b ov=%b, want 0 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests++;
    if (occupancy !== '0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL flush_after: occ=%0d ov=%b od=%h ir=%b, want 0 0 0 1",
               occupancy, out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] q_data [$];
    int           q_edge [$];
    int           edge_n = 0;
    logic         exp_ready, exp_valid, acc, take;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = W'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      // Not full, or the last stage is leaving: stage 0 can accept.
      exp_ready = (q_data.size() < int'(D)) || out_ready;
      // The oldest payload moves one stage per edge until it reaches the last stage.
      exp_valid = (q_data.size() > 0) && (edge_n - q_edge[0] >= int'(D) - 1);
      tests++;
      if (in_ready !== exp_ready || out_valid !== exp_valid || occupancy !== CW'(q_data.size()) ||
          (exp_valid && out_data !== q_data[0])) begin
        fails++;
        $display("FAIL random: c=%0d ir=%b ov=%b occ=%0d od=%h, want %b %b %0d %h",
                 c, in_ready, out_valid, occupancy, out_data, exp_ready, exp_valid,
                 q_data.size(), (q_data.size() > 0) ? q_data[0] : '0);
      end
      acc  = in_valid && exp_ready;
      take = exp_valid && out_ready;
      @(posedge clk);
      edge_n++;
      if (take) begin
        void'(q_data.pop_front());
        void'(q_edge.pop_front());
      end
      if (acc) begin
        q_data.push_back(in_data);
        q_edge.push_back(edge_n);
      end
      #1;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
